// File: rtl/ch0re_pkg.sv
// ch0re_pkg: shared core widths and the fetch-state encoding
package ch0re_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  typedef enum logic [1:0] {ST_RUN, ST_EXC, ST_HALT} fetch_state_e;
endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: circular FIFO with synchronous flush and occupancy count
// Ports: clk, rst_ (async, active-high), push_i/data_i write side,
// pop_i/data_o read side (data_o is the head entry), flush_i empties the
// queue, count_o is the current occupancy.
module ifetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    wr_d  = flush_i ? '0 : push_i ? inc(wr_q) : wr_q;
    rd_d  = flush_i ? '0 : pop_i ? inc(rd_q) : rd_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: credit-limited instruction fetch with redirect and misaligned-target trap
// Ports: clk, rst_ (async, active-high); o_imem_req/o_imem_addr issue word
// reads, i_imem_rdata returns one cycle later; i_redirect_valid/i_redirect_pc
// steer fetch; o_valid/i_ready handshake {o_instr, o_pc, o_npc,
// o_exc_misaligned} to decode.
module ifetch_unit
  import ch0re_pkg::ILEN, ch0re_pkg::fetch_state_e, ch0re_pkg::ST_RUN,
         ch0re_pkg::ST_EXC, ch0re_pkg::ST_HALT;
#(
  parameter int              XLEN            = ch0re_pkg::XLEN,
  parameter int              IMEM_DEPTH      = 2048,
  parameter int              IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH),
  parameter int              FQ_DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst_,
  output logic                       o_imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [ILEN-1:0]            i_imem_rdata,
  input  logic                       i_redirect_valid,
  input  logic [XLEN-1:0]            i_redirect_pc,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [ILEN-1:0]            o_instr,
  output logic [XLEN-1:0]            o_pc,
  output logic [XLEN-1:0]            o_npc,
  output logic                       o_exc_misaligned
);
  localparam int CW = $clog2(FQ_DEPTH+1);
  localparam int EW = ILEN + XLEN + 1;
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            infl_q, infl_d;
  logic [CW-1:0]   count, occ;
  logic [EW-1:0]   head, wdata;
  logic            empty, pop, push, req;
  always_comb begin
    empty   = count == '0;
    o_valid = !empty && !i_redirect_valid;
    pop     = o_valid && i_ready;
    // Entries already owed to the queue after this cycle's pop; a new request
    // is only allowed if its response is guaranteed a slot.
    occ     = count - CW'(pop) + CW'(infl_q);
    req     = !rst_ && state_q == ST_RUN && !i_redirect_valid && occ < CW'(FQ_DEPTH);
    // Any redirect kills the response arriving this cycle.
    push    = !i_redirect_valid && (infl_q || state_q == ST_EXC);
    // pc_q has already advanced past the inflight request, so its PC is pc_q-4.
    wdata   = state_q == ST_EXC ? {{ILEN{1'b0}}, pc_q, 1'b1}
                                : {i_imem_rdata, pc_q - XLEN'(4), 1'b0};
    state_d = i_redirect_valid ? (i_redirect_pc[1:0] == 2'b00 ? ST_RUN : ST_EXC)
                               : state_q == ST_EXC ? ST_HALT : state_q;
    pc_d    = i_redirect_valid ? i_redirect_pc : req ? pc_q + XLEN'(4) : pc_q;
    infl_d  = req;
    o_imem_req  = req;
    o_imem_addr = rst_ ? '0 : pc_q[IMEM_ADDR_WIDTH+1:2];
    {o_instr, o_pc, o_exc_misaligned} = empty ? '0 : head;
    o_npc = empty ? '0 : o_pc + XLEN'(4);
  end
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= infl_d;
    end
  end
  ifetch_queue #(.W(EW), .DEPTH(FQ_DEPTH)) u_queue (
    .clk     (clk),
    .rst_    (rst_),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_redirect_valid),
    .data_i  (wdata),
    .data_o  (head),
    .count_o (count)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and randomized checks of ifetch_unit against a stream-level model
module tb_ifetch_unit;
  localparam int DEPTH = 2048;
  localparam int AW = 11;
  localparam int FQ = 4;
  localparam logic [63:0] RPC2 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam int M_RUN = 0, M_EXC = 1, M_DONE = 2;
  logic clk = 1'b0;
  logic rst_;
  logic imem_req, redir, ready, valid, exc;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_rdata, instr;
  logic [63:0] redir_pc, pc, npc;
  logic req2, valid2, exc2;
  logic [AW-1:0] addr2;
  logic [31:0] rdata2, instr2;
  logic [63:0] pc2, npc2;
  logic [31:0] mem [DEPTH];
  int n_chk = 0, n_err = 0;
  int cyc = 0, n_pop = 0, n_pop2 = 0, n_exc = 0, outstanding = 0;
  int first_req = -1, first_val = -1, mode = M_RUN, p0;
  logic [63:0] exp_pc, req_pc, exp2, first_pc, prev_pc;
  logic [31:0] prev_instr;
  logic prev_exc, stalled = 1'b0, got_first = 1'b0, last_req, last_valid;

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= imem_req ? mem[imem_addr] : 32'hdead_beef;
  always @(posedge clk) rdata2 <= req2 ? mem[addr2] : 32'hdead_beef;

  ifetch_unit dut (
    .clk(clk), .rst_(rst_), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_rdata(imem_rdata), .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
    .o_valid(valid), .i_ready(ready), .o_instr(instr), .o_pc(pc), .o_npc(npc),
    .o_exc_misaligned(exc)
  );
  ifetch_unit #(.RESET_PC(RPC2)) dut2 (
    .clk(clk), .rst_(rst_), .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_rdata(rdata2), .i_redirect_valid(1'b0), .i_redirect_pc(64'h0),
    .o_valid(valid2), .i_ready(1'b1), .o_instr(instr2), .o_pc(pc2), .o_npc(npc2),
    .o_exc_misaligned(exc2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: inputs were set at the preceding negedge; sample 1ns later.
  task automatic tick();
    logic xfer;
    #1;
    cyc++;
    if (rst_) begin
      check("rst_valid", valid, 0);
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_instr", instr, 0);
      check("rst_pc", pc, 0);
      check("rst_npc", npc, 0);
      check("rst_exc", exc, 0);
      check("rst2_req", req2, 0);
      check("rst2_addr", addr2, 0);
      check("rst2_npc", npc2, 0);
      mode = M_RUN; exp_pc = 0; req_pc = 0; exp2 = RPC2; outstanding = 0;
      n_pop = 0; n_pop2 = 0; stalled = 0; got_first = 0; first_req = -1; first_val = -1;
    end else begin
      xfer = valid && ready && !redir;
      if (first_req < 0 && imem_req) first_req = cyc;
      if (first_val < 0 && valid) first_val = cyc;
      if (stalled) begin
        check("stall_pc", pc, prev_pc);
        check("stall_instr", instr, prev_instr);
        check("stall_exc", exc, prev_exc);
        if (!redir) check("stall_valid", valid, 1);
      end
      if (redir) begin
        check("redir_valid", valid, 0);
        check("redir_req", imem_req, 0);
      end
      if (xfer) begin
        if (mode == M_DONE) check("extra_xfer", valid, 0);
        else begin
          check("xfer_pc", pc, exp_pc);
          check("xfer_instr", instr, mode == M_EXC ? 32'h0 : mem[exp_pc[AW+1:2]]);
          check("xfer_exc", exc, mode == M_EXC);
          check("xfer_npc", npc, exp_pc + 64'd4);
          if (!got_first) begin got_first = 1; first_pc = pc; end
          if (mode == M_EXC) begin n_exc += int'(exc); mode = M_DONE; end
          else begin exp_pc += 4; outstanding--; end
          n_pop++;
        end
      end
      if (imem_req) begin
        if (mode != M_RUN) check("halt_req", imem_req, 0);
        else begin
          check("req_addr", imem_addr, req_pc[AW+1:2]);
          req_pc += 4;
          outstanding++;
          check("credit", outstanding > FQ, 0);
        end
      end
      if (redir) begin
        mode = redir_pc[1:0] == 2'b00 ? M_RUN : M_EXC;
        exp_pc = redir_pc; req_pc = redir_pc; outstanding = 0;
      end
      stalled = valid && !ready && !redir;
      prev_pc = pc; prev_instr = instr; prev_exc = exc;
      last_req = imem_req; last_valid = valid;
      if (valid2) begin
        check("wrap_pc", pc2, exp2);
        check("wrap_instr", instr2, mem[exp2[AW+1:2]]);
        check("wrap_npc", npc2, exp2 + 64'd4);
        check("wrap_exc", exc2, 0);
        exp2 += 4;
        n_pop2++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = (i < 8) ? 32'h100 + 32'(i) : 32'($urandom);
    rst_ = 1; ready = 0; redir = 0; redir_pc = 0;
    @(negedge clk);
    repeat (3) tick();
    rst_ = 0; ready = 1;
    repeat (12) tick();
    check("first_latency", 64'(first_val - first_req), 2);
    check("first_req_cycle", 64'(first_req), 4);
    check("throughput", 64'(n_pop), 10);
    check("wrap_count", 64'(n_pop2), 10);
    ready = 0;
    repeat (10) tick();
    check("stall_held", 64'(outstanding), FQ);
    check("stall_no_req", last_req, 0);
    check("stall_valid_end", last_valid, 1);
    ready = 1;
    tick();
    ready = 0; redir = 1; redir_pc = 64'h40;
    tick();
    redir = 0; ready = 1; p0 = n_pop;
    repeat (8) tick();
    check("redir40_pops", 64'(n_pop - p0), 6);
    redir = 1; redir_pc = 64'h42;
    tick();
    redir = 0;
    repeat (10) tick();
    check("exc_count", 64'(n_exc), 1);
    redir = 1; redir_pc = 64'h80;
    tick();
    redir = 0; p0 = n_pop;
    repeat (8) tick();
    check("redir80_pops", 64'(n_pop - p0), 6);
    ready = 0; redir = 1; redir_pc = 64'h200;
    tick();
    redir = 0;
    repeat (3) tick();
    check("pre_rst_owed", 64'(outstanding), 3);
    rst_ = 1;
    tick();
    rst_ = 0; ready = 1;
    repeat (6) tick();
    check("post_rst_got", got_first, 1);
    check("post_rst_pc", first_pc, 0);
    repeat (3000) begin
      ready = $urandom_range(0, 3) != 0;
      redir = $urandom_range(0, 39) == 0;
      redir_pc = {$urandom, $urandom};
      redir_pc[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter XLEN, 64, PC and address width in bits.
REQ-002 Parameter IMEM_DEPTH, 2048, instruction memory depth in 32-bit words.
REQ-003 Parameter IMEM_ADDR_WIDTH, $clog2(IMEM_DEPTH), word-address width.
REQ-004 Parameter FQ_DEPTH, 4, fetch queue entries; legal range is 2 to 16.
REQ-005 Parameter RESET_PC, 64'h0, first fetch address.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_  in  1  asynchronous, active-high reset.
REQ-008 o_imem_req  out  1  fetch request this cycle.
REQ-009 o_imem_addr  out  IMEM_ADDR_WIDTH  word address = PC[IMEM_ADDR_WIDTH+1:2].
REQ-010 i_imem_rdata  in  32  read data, valid exactly one cycle after o_imem_req.
REQ-011 i_redirect_valid  in  1  branch/jump/trap redirect strobe.
REQ-012 i_redirect_pc  in  XLEN  redirect target.
REQ-013 o_valid  out  1  instruction available to decode.
REQ-014 i_ready  in  1  decode accepts instruction.
REQ-015 o_instr  out  32  instruction word.
REQ-016 o_pc  out  XLEN  instruction address.
REQ-017 o_npc  out  XLEN  o_pc + 4, modulo 2^XLEN.
REQ-018 o_exc_misaligned  out  1  entry carries an instruction-address-misaligned exception (IALIGN=32).

Function
REQ-019 A transfer SHALL occur on any cycle with o_valid=1, i_ready=1 and i_redirect_valid=0; this is a pop.
REQ-020 While o_valid=1 and i_ready=0, o_instr, o_pc and o_exc_misaligned SHALL hold stable.
REQ-021 The FIFO queue SHALL store {instr, pc, exc}; o_valid = queue not empty, masked to 0 in any cycle with i_redirect_valid=1.
REQ-022 A request SHALL issue in state RUN only when (count - pop + inflight) < FQ_DEPTH; inflight is 1 if a request was issued the previous cycle and not cancelled.
REQ-023 The returning i_imem_rdata SHALL be pushed, with its PC, one cycle after its request, so o_valid rises 2 cycles after o_imem_req.
REQ-024 Sustained throughput SHALL be 1 instruction per cycle while i_ready=1; push and pop in the same cycle are legal at any occupancy.
REQ-025 PC SHALL advance by 4 per issued request, wrapping modulo 2^XLEN; o_imem_addr wraps modulo IMEM_DEPTH.
REQ-026 States: RUN (normal fetch), EXC (push one exception entry), HALT (no requests).
REQ-027 On i_redirect_valid=1 in any state: flush the queue, cancel any inflight response (drop next-cycle data), PC <= i_redirect_pc, no request that cycle.
REQ-028 After a redirect, the next state SHALL be RUN if i_redirect_pc[1:0]==0, otherwise EXC.
REQ-029 EXC SHALL push {instr=0, pc=redirect pc, exc=1} into the empty queue, then go to HALT.
REQ-030 HALT SHALL issue no requests and leave only on a redirect.
REQ-031 A redirect arriving in EXC or HALT SHALL be obeyed as in REQ-027 and REQ-028.

Reset
REQ-032 While rst_=1: PC=RESET_PC, queue empty, inflight=0, state RUN, and o_valid, o_imem_req, o_imem_addr, o_instr, o_pc, o_npc, o_exc_misaligned are all 0.
REQ-033 Reset asserted mid-operation SHALL take effect immediately; a read response landing on the cycle after deassertion SHALL be ignored.
REQ-034 The first request SHALL issue in the first cycle after rst_ deasserts, at address RESET_PC.

Structure
REQ-035 XLEN, ILEN=32 and the fetch-state enum (RUN/EXC/HALT) SHALL live in the shared package ch0re_pkg.
REQ-036 The queue SHALL be a separate sub-module, ifetch_queue, parametrised by width and depth, with count, push, pop and flush ports.
REQ-037 The instruction memory is external; ifetch_unit SHALL instantiate no memory.

Verification
REQ-038 Reset release, memory preloaded with words 0..7 = 0x100+i, i_ready=1 -> requests issue at PC 0,4,8,...; first o_valid 2 cycles after first request with o_instr=0x100, o_pc=0, o_npc=4; thereafter 1 instruction/cycle.
REQ-039 i_ready=0 for 10 cycles with FQ_DEPTH=4 -> exactly 4 entries held, o_imem_req=0 once credits are exhausted, outputs stable; on release, no loss or duplication, in order.
REQ-040 Redirect to 0x40 while 3 entries queued and 1 inflight -> o_valid=0 that cycle; next o_instr is mem[16] with o_pc=0x40; no stale entry appears.
REQ-041 Redirect to 0x42 -> one entry with o_exc_misaligned=1, o_pc=0x42, o_instr=0; no requests afterwards; a later redirect to 0x80 resumes fetch at 0x80.
REQ-042 RESET_PC=2^XLEN-8 -> fetch PCs are ...F8, ...FC, 0; o_npc of ...FC is 0.
REQ-043 Assert rst_ while 2 entries are queued and 1 is inflight -> all outputs 0 immediately; after release the first o_pc is RESET_PC.
